dem_select18: RTL
=================

// Module: dem_select18
// PURPOSE
//  Sequential element selector for the 18-unit DAC mismatch-shaping path; consumer of a max-reduction.
//  Takes a snapshot of the 18 unit-element shaping states and a requested element count k.
//  Selects the k elements with the largest states, one per cycle, using one masked max/argmax tree.
//  Returns an 18-bit unit-element enable vector to the DAC drive stage, plus a done pulse.
// PARAMETERS
//  N      18   number of unit elements
//  W      7    shaping-state width (unsigned)
//  KW     5    width of count input; must satisfy 2**KW > N
//  IDXW   5    element index width, ceil(log2(N))
// PORTS
//  clk      in   1     system clock, rising edge
//  rst_n    in   1     asynchronous active-low reset
//  start_i  in   1     request pulse; sampled only in IDLE
//  k_i      in   KW    number of elements to enable; values > N saturate to N
//  state_i  in   N*W   packed states; element j = state_i[j*W +: W]
//  busy_o   out  1     high from the cycle after an accepted start through the DONE cycle
//  done_o   out  1     one-cycle pulse; sel_o/max_o valid from this cycle
//  sel_o    out  N     element enables; bit j=1 means element j selected
//  max_o    out  W     largest state in the snapshot (first selection); 0 when k=0
// BEHAVIOUR
//  Reset: state=IDLE; busy_o=0, done_o=0, sel_o=0, max_o=0; snapshot and counter cleared.
//  FSM: IDLE -> SEARCH -> DONE -> IDLE.
//   IDLE: on start_i=1, latch state_i, latch kk=min(k_i,N), clear sel_o and max_o.
//         Next state is SEARCH if kk>0, otherwise DONE.
//   SEARCH: the tree evaluates {~sel_o[j], state[j]} per element, so masked elements never win.
//           Ties resolve to the lowest index.
//           Set sel_o[idx]; on the first SEARCH cycle, register max_o=value. Decrement kk.
//           When kk reaches 0, go to DONE.
//   DONE: done_o=1 for exactly one cycle, then go to IDLE.
//  Latency: start sampled at edge t.
//   SEARCH occupies t+1..t+k.
//   done_o is high in cycle t+k+1, so k=0 gives done in t+1 and k=18 gives done in t+19.
//  sel_o and max_o hold their value after DONE until the next accepted start.
//   They must not change while busy_o=0.
//  start_i while busy_o=1 (including the DONE cycle) is ignored and not queued.
//  start_i in the IDLE cycle right after DONE is accepted (back-to-back operation).
//  state_i is used only at acceptance; later changes have no effect on the current operation.
//  popcount(sel_o) equals min(k_i,N) at done_o. All comparisons are unsigned W-bit.
//  Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no done_o.
//  No X propagation: every register has a reset value.
// STRUCTURE
//  Shared package dem_pkg:
//   - constants N, W, KW, IDXW
//   - FSM state encoding IDLE/SEARCH/DONE
//   - helper to extract element j from a packed bus
//  Sub-module max_idx_tree (combinational):
//   - N x (W+1)-bit inputs; outputs max value (W) and index (IDXW)
//   - 5-level pairwise tree; lower index wins ties
//   - exactly one instance
//  The top level holds the FSM, snapshot register, kk counter, sel_o/max_o registers.
// TESTING
//  1 Distinct states 0..17 (element j=j), k=3.
//    -> done_o at t+4; sel_o=18'h38000; max_o=17; busy_o high for cycles t+1..t+4.
//  2 All states 7'h40, k=5.
//    -> ties give sel_o=18'h0001F; max_o=7'h40.
//  3 k=0, arbitrary states.
//    -> done_o at t+1; sel_o=0; max_o=0.
//  4 k=18 and k=31, random states.
//    -> done_o at t+19; sel_o=18'h3FFFF; max_o equals the reference-model maximum.
//  5 Second start during SEARCH and during DONE, plus back-to-back start in the IDLE cycle after done.
//    -> first result unchanged; only the back-to-back request runs.
//  6 rst_n low at t+2 of a k=10 run.
//    -> outputs 0 immediately; no done_o; a new start after release completes normally.
//  Plus a random regression against a sort-based model, checking sel_o, max_o and timing.

Source files
------------

// File: rtl/dem_pkg.sv
// dem_pkg: shared constants, FSM encoding and bus helper for the 18-unit DEM selector
package dem_pkg;
  localparam int N = 18;
  localparam int W = 7;
  localparam int KW = 5;
  localparam int IDXW = 5;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  function automatic logic [W-1:0] elem(input logic [N*W-1:0] bus, input int j);
    return bus[j*W +: W];
  endfunction
endpackage

// File: rtl/max_idx_tree.sv
// max_idx_tree: combinational max/argmax over N (W+1)-bit entries, lowest index wins ties
// Ports: din (packed N x (W+1) entries), max_val (low W bits of winner), max_idx (winner index)
module max_idx_tree
  import dem_pkg::*;
(
  input  logic [N*(W+1)-1:0] din,
  output logic [W-1:0]       max_val,
  output logic [IDXW-1:0]    max_idx
);
  logic [W:0]      v  [6][32];
  logic [IDXW-1:0] ix [6][32];
  always_comb begin
    v = '{default: '0};
    ix = '{default: '0};
    for (int i = 0; i < 32; i++) ix[0][i] = IDXW'(i);
    for (int i = 0; i < N; i++) v[0][i] = din[i*(W+1) +: W+1];
    // Padding leaves are zero with high indices, so they never beat a real entry.
    // The right child wins only when strictly larger, keeping the lower index on ties.
    for (int l = 0; l < 5; l++)
      for (int i = 0; i < (16 >> l); i++) begin
        v[l+1][i] = v[l][2*i+1] > v[l][2*i] ? v[l][2*i+1] : v[l][2*i];
        ix[l+1][i] = v[l][2*i+1] > v[l][2*i] ? ix[l][2*i+1] : ix[l][2*i];
      end
    max_val = v[5][0][W-1:0];
    max_idx = ix[5][0];
  end
endmodule

// File: rtl/dem_select18.sv
// dem_select18: picks the k largest of 18 shaping states, one per cycle, into an enable vector
// Ports: clk, rst_n (async low), start_i, k_i, state_i -> busy_o, done_o, sel_o, max_o
module dem_select18
  import dem_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [KW-1:0]  k_i,
  input  logic [N*W-1:0] state_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [N-1:0]   sel_o,
  output logic [W-1:0]   max_o
);
  localparam logic [KW-1:0] NK = KW'(N);
  state_t st, nx;
  logic [N*W-1:0] snap;
  logic [KW-1:0] kk, k_sat;
  logic [N*(W+1)-1:0] din;
  logic [W-1:0] mval;
  logic [IDXW-1:0] midx;
  assign k_sat = k_i > NK ? NK : k_i;
  assign busy_o = st != IDLE;
  assign done_o = st == DONE;
  // Already-selected elements lose their top bit, so any unselected element outranks them.
  always_comb begin
    din = '0;
    for (int j = 0; j < N; j++) din[j*(W+1) +: W+1] = {~sel_o[j], elem(snap, j)};
  end
  max_idx_tree u_tree (
    .din     (din),
    .max_val (mval),
    .max_idx (midx)
  );
  always_comb begin
    nx = st;
    case (st)
      IDLE:    if (start_i) nx = k_sat == '0 ? DONE : SEARCH;
      SEARCH:  if (kk == KW'(1)) nx = DONE;
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      snap <= '0;
      kk <= '0;
      sel_o <= '0;
      max_o <= '0;
    end else begin
      st <= nx;
      if (st == IDLE && start_i) begin
        snap <= state_i;
        kk <= k_sat;
        sel_o <= '0;
        max_o <= '0;
      end else if (st == SEARCH) begin
        sel_o <= sel_o | (N'(1) << midx);
        // sel_o is still empty only on the first search cycle, whose winner is the overall max.
        if (sel_o == '0) max_o <= mval;
        kk <= kk - KW'(1);
      end
    end
endmodule
